// File: rtl/safe_pkg.sv
// Shared definitions for the digital safe: state encoding and keypad codes.
package safe_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    INPUT   = 4'd1,
    CHECK   = 4'd2,
    OPEN    = 4'd3,
    FAIL    = 4'd4,
    LOCKOUT = 4'd5,
    SETPW   = 4'd6
  } state_t;

  localparam logic [3:0] KEY_CLR = 4'hC;
  localparam logic [3:0] KEY_ENT = 4'hE;
  localparam logic [3:0] KEY_SET = 4'hF;

endpackage

// File: rtl/safe_countdown.sv
// Loadable min:sec down-counter; expire strobes on the tick that reaches 0:00.
module safe_countdown (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       tick,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       expire
);

  assign expire = tick && (min == '0) && (sec == 6'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min <= '0;
      sec <= '0;
    end else if (load) begin
      min <= load_min;
      sec <= load_sec;
    end else if (tick && ((min != '0) || (sec != '0))) begin
      if (sec == '0) begin
        min <= min - 6'd1;
        sec <= 6'd59;
      end else begin
        sec <= sec - 6'd1;
      end
    end
  end

endmodule

// File: rtl/safe_control_fsm.sv
// Safe sequencer: password, attempt counter, digit entry and countdown timers.
module safe_control_fsm
  import safe_pkg::*;
#(
  parameter int unsigned MAX_CHANCE   = 3,
  parameter logic [15:0] DEFAULT_PW   = 16'h1234,
  parameter int unsigned INPUT_TO_SEC = 30,
  parameter int unsigned OPEN_SEC     = 10,
  parameter int unsigned FAIL_SEC     = 2,
  parameter int unsigned LOCK_MIN     = 1,
  parameter int unsigned LOCK_SEC     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [3:0]  state,
  output logic [3:0]  chance_count,
  output logic [15:0] input_data,
  output logic [5:0]  timer_min,
  output logic [5:0]  timer_sec,
  output logic        pw_updated
);

  state_t      state_q, state_d;
  logic [3:0]  chance_q, chance_d, chance_dec;
  logic [15:0] data_q, data_d, pw_q, pw_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        upd_q, upd_d;
  logic        is_digit, is_clr, is_ent, is_set, key_used;
  logic        load, expire;
  logic [5:0]  load_min, load_sec;

  assign is_digit   = key_valid && (key_code <= 4'd9);
  assign is_clr     = key_valid && (key_code == KEY_CLR);
  assign is_ent     = key_valid && (key_code == KEY_ENT);
  assign is_set     = key_valid && (key_code == KEY_SET);
  assign chance_dec = chance_q - 4'd1;

  // A key that is acted on swallows a coincident tick; ignored keys let it through.
  always_comb begin
    key_used = 1'b0;
    case (state_q)
      IDLE:         key_used = is_digit;
      INPUT, SETPW: key_used = (is_digit && (cnt_q < 3'd4)) || is_clr ||
                               (is_ent && (cnt_q == 3'd4));
      OPEN:         key_used = is_ent || is_set;
      default:      key_used = 1'b0;
    endcase
  end

  safe_countdown u_countdown (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_min (load_min),
    .load_sec (load_sec),
    .tick     (tick_1hz && !key_used),
    .min      (timer_min),
    .sec      (timer_sec),
    .expire   (expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      chance_q <= 4'(MAX_CHANCE);
      data_q   <= '0;
      cnt_q    <= '0;
      pw_q     <= DEFAULT_PW;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      chance_q <= chance_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      pw_q     <= pw_d;
      upd_q    <= upd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    chance_d = chance_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    pw_d     = pw_q;
    upd_d    = 1'b0;
    load     = 1'b0;
    load_min = '0;
    load_sec = '0;
    case (state_q)
      IDLE: if (is_digit) begin
        state_d  = INPUT;
        data_d   = {12'h000, key_code};
        cnt_d    = 3'd1;
        load     = 1'b1;
        load_sec = 6'(INPUT_TO_SEC);
      end
      INPUT, SETPW: begin
        if (is_digit && (cnt_q < 3'd4)) begin
          data_d   = {data_q[11:0], key_code};
          cnt_d    = cnt_q + 3'd1;
          load     = 1'b1;
          load_sec = 6'(INPUT_TO_SEC);
        end else if (is_clr) begin
          data_d   = '0;
          cnt_d    = '0;
          load     = 1'b1;
          load_sec = 6'(INPUT_TO_SEC);
        end else if (is_ent && (cnt_q == 3'd4)) begin
          if (state_q == INPUT) begin
            state_d = CHECK;
          end else begin
            pw_d     = data_q;
            upd_d    = 1'b1;
            state_d  = OPEN;
            data_d   = '0;
            cnt_d    = '0;
            load     = 1'b1;
            load_sec = 6'(OPEN_SEC);
          end
        end else if (expire) begin
          state_d = IDLE;
          data_d  = '0;
          cnt_d   = '0;
        end
      end
      CHECK: begin
        data_d = '0;
        cnt_d  = '0;
        load   = 1'b1;
        if (data_q == pw_q) begin
          state_d  = OPEN;
          chance_d = 4'(MAX_CHANCE);
          load_sec = 6'(OPEN_SEC);
        end else begin
          chance_d = chance_dec;
          if (chance_dec == '0) begin
            state_d  = LOCKOUT;
            load_min = 6'(LOCK_MIN);
            load_sec = 6'(LOCK_SEC);
          end else begin
            state_d  = FAIL;
            load_sec = 6'(FAIL_SEC);
          end
        end
      end
      FAIL: if (expire) state_d = IDLE;
      OPEN: begin
        if (is_ent) begin
          state_d = IDLE;
          load    = 1'b1;
        end else if (is_set) begin
          state_d  = SETPW;
          data_d   = '0;
          cnt_d    = '0;
          load     = 1'b1;
          load_sec = 6'(INPUT_TO_SEC);
        end else if (expire) begin
          state_d = IDLE;
        end
      end
      LOCKOUT: if (expire) begin
        state_d  = IDLE;
        chance_d = 4'(MAX_CHANCE);
      end
      default: state_d = IDLE;
    endcase
  end

  assign state        = state_q;
  assign chance_count = chance_q;
  assign input_data   = data_q;
  assign pw_updated   = upd_q;

endmodule

// File: tb/tb_safe_control_fsm.sv
// Scoreboard bench for safe_control_fsm: directed key/tick vectors, queued expectations.
module tb_safe_control_fsm;
  import safe_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick_1hz = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = '0;
  logic [3:0]  state, chance_count;
  logic [15:0] input_data;
  logic [5:0]  timer_min, timer_sec;
  logic        pw_updated;

  typedef struct {
    bit          care;
    logic [3:0]  st;
    logic [3:0]  ch;
    logic [15:0] data;
    logic [5:0]  mn;
    logic [5:0]  sc;
    logic        upd;
  } exp_t;

  exp_t q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned step_no = 0;

  safe_control_fsm #(
    .MAX_CHANCE(3), .DEFAULT_PW(16'h1234), .INPUT_TO_SEC(30),
    .OPEN_SEC(10), .FAIL_SEC(2), .LOCK_MIN(1), .LOCK_SEC(0)
  ) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .key_valid(key_valid),
    .key_code(key_code), .state(state), .chance_count(chance_count),
    .input_data(input_data), .timer_min(timer_min), .timer_sec(timer_sec),
    .pw_updated(pw_updated)
  );

  always #5 clk = ~clk;

  function automatic exp_t E(logic [3:0] st, logic [3:0] ch, logic [15:0] data,
                             logic [5:0] mn, logic [5:0] sc, logic upd);
    exp_t e;
    e.care = 1'b1; e.st = st; e.ch = ch; e.data = data;
    e.mn = mn; e.sc = sc; e.upd = upd;
    return e;
  endfunction

  function automatic exp_t NC();
    exp_t e;
    e.care = 1'b0; e.st = '0; e.ch = '0; e.data = '0;
    e.mn = '0; e.sc = '0; e.upd = 1'b0;
    return e;
  endfunction

  // One cycle of stimulus; expectation describes outputs after the next posedge.
  task automatic drive(bit kv, logic [3:0] kc, bit tk, bit r, exp_t e);
    @(negedge clk);
    rst = r; key_valid = kv; key_code = kc; tick_1hz = tk;
    q.push_back(e);
  endtask

  task automatic key(logic [3:0] k, exp_t e);      drive(1'b1, k, 1'b0, 1'b1, e); endtask
  task automatic key_tick(logic [3:0] k, exp_t e); drive(1'b1, k, 1'b1, 1'b1, e); endtask
  task automatic tick(exp_t e);                    drive(1'b0, 4'h0, 1'b1, 1'b1, e); endtask
  task automatic idle(exp_t e);                    drive(1'b0, 4'h0, 1'b0, 1'b1, e); endtask

  // Enter four digits then ENT; outputs checked after each digit and in CHECK.
  task automatic enter_code(logic [15:0] code, logic [3:0] ch);
    logic [15:0] part;
    for (int i = 0; i < 4; i++) begin
      part = code >> (4 * (3 - i));
      key(code[15 - 4*i -: 4], E(INPUT, ch, part, 6'd0, 6'd30, 1'b0));
    end
    key(KEY_ENT, E(CHECK, ch, code, 6'd0, 6'd30, 1'b0));
  endtask

  task automatic cmp(string name, logic [15:0] act, logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL step %0d %s: got %h expected %h", step_no, name, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        step_no++;
        if (e.care) begin
          cmp("state",      16'(state),        16'(e.st));
          cmp("chance",     16'(chance_count), 16'(e.ch));
          cmp("input_data", input_data,        e.data);
          cmp("timer",      {4'h0, timer_min, timer_sec}, {4'h0, e.mn, e.sc});
          cmp("pw_updated", 16'(pw_updated),   16'(e.upd));
        end
      end
    end
  end

  initial begin : stim
    // Reset
    drive(1'b0, 4'h0, 1'b0, 1'b0, E(IDLE, 3, 16'h0000, 0, 0, 0));
    drive(1'b0, 4'h0, 1'b1, 1'b0, E(IDLE, 3, 16'h0000, 0, 0, 0));
    idle(E(IDLE, 3, 16'h0000, 0, 0, 0));

    // Correct code opens; relock on timer
    enter_code(16'h1234, 3);
    idle(E(OPEN, 3, 16'h0000, 0, 10, 0));
    for (int i = 1; i < 10; i++) tick(E(OPEN, 3, 16'h0000, 0, 6'(10 - i), 0));
    tick(E(IDLE, 3, 16'h0000, 0, 0, 0));
    tick(E(IDLE, 3, 16'h0000, 0, 0, 0));

    // Three wrong attempts then lockout
    for (int r = 0; r < 2; r++) begin
      enter_code(16'h1111, 4'(3 - r));
      idle(E(FAIL, 4'(2 - r), 16'h0000, 0, 2, 0));
      key_tick(4'h1, E(FAIL, 4'(2 - r), 16'h0000, 0, 1, 0));
      tick(E(IDLE, 4'(2 - r), 16'h0000, 0, 0, 0));
    end
    enter_code(16'h1111, 1);
    idle(E(LOCKOUT, 0, 16'h0000, 1, 0, 0));
    tick(E(LOCKOUT, 0, 16'h0000, 0, 59, 0));
    key_tick(4'h5, E(LOCKOUT, 0, 16'h0000, 0, 58, 0));
    key(KEY_ENT, E(LOCKOUT, 0, 16'h0000, 0, 58, 0));
    for (int k = 3; k < 60; k++) tick(E(LOCKOUT, 0, 16'h0000, 0, 6'(60 - k), 0));
    tick(E(IDLE, 3, 16'h0000, 0, 0, 0));

    // Short entry, overflow digit, clear
    key(4'h1, NC());
    key(4'h2, NC());
    key(4'h3, E(INPUT, 3, 16'h0123, 0, 30, 0));
    key(KEY_ENT, E(INPUT, 3, 16'h0123, 0, 30, 0));
    key(4'h4, E(INPUT, 3, 16'h1234, 0, 30, 0));
    key_tick(4'h5, E(INPUT, 3, 16'h1234, 0, 29, 0));
    key(KEY_CLR, E(INPUT, 3, 16'h0000, 0, 30, 0));
    key(KEY_ENT, E(INPUT, 3, 16'h0000, 0, 30, 0));

    // Inactivity timeout, with a digit rescuing the 30th tick first
    key(4'h7, E(INPUT, 3, 16'h0007, 0, 30, 0));
    for (int i = 1; i < 30; i++) tick(E(INPUT, 3, 16'h0007, 0, 6'(30 - i), 0));
    key_tick(4'h8, E(INPUT, 3, 16'h0078, 0, 30, 0));
    for (int i = 1; i < 30; i++) tick(E(INPUT, 3, 16'h0078, 0, 6'(30 - i), 0));
    tick(E(IDLE, 3, 16'h0000, 0, 0, 0));

    // Change password
    enter_code(16'h1234, 3);
    idle(E(OPEN, 3, 16'h0000, 0, 10, 0));
    key(KEY_SET, E(SETPW, 3, 16'h0000, 0, 30, 0));
    key(4'h9, NC());
    key(4'h8, NC());
    key(4'h7, E(SETPW, 3, 16'h0987, 0, 30, 0));
    key(4'h6, E(SETPW, 3, 16'h9876, 0, 30, 0));
    key(KEY_ENT, E(OPEN, 3, 16'h0000, 0, 10, 1));
    idle(E(OPEN, 3, 16'h0000, 0, 10, 0));
    key(KEY_ENT, E(IDLE, 3, 16'h0000, 0, 0, 0));
    enter_code(16'h1234, 3);
    idle(E(FAIL, 2, 16'h0000, 0, 2, 0));
    tick(NC());
    tick(E(IDLE, 2, 16'h0000, 0, 0, 0));
    enter_code(16'h9876, 2);
    idle(E(OPEN, 3, 16'h0000, 0, 10, 0));
    key(KEY_ENT, E(IDLE, 3, 16'h0000, 0, 0, 0));

    // Reset mid-lockout restores the default password
    for (int r = 0; r < 3; r++) begin
      enter_code(16'h1111, 4'(3 - r));
      idle(NC());
      if (r < 2) begin
        tick(NC());
        tick(NC());
      end
    end
    for (int k = 1; k < 30; k++) tick(NC());
    idle(E(LOCKOUT, 0, 16'h0000, 0, 31, 0));
    drive(1'b0, 4'h0, 1'b1, 1'b0, E(IDLE, 3, 16'h0000, 0, 0, 0));
    idle(E(IDLE, 3, 16'h0000, 0, 0, 0));
    enter_code(16'h1234, 3);
    idle(E(OPEN, 3, 16'h0000, 0, 10, 0));

    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
